// File: rtl/cci_mpf_shim_pkg.sv
// Shared types and constants for the MPF shim TX request buffer.
package cci_mpf_shim_pkg;

   localparam int unsigned TX_MAX_CH        = 4;
   localparam int unsigned TX_DEFAULT_DEPTH = 64;
   localparam int unsigned TX_DEFAULT_SLACK = 8;

   // Wide enough to name any of the TX_MAX_CH channels.
   typedef logic [$clog2(TX_MAX_CH)-1:0] t_tx_ch_idx;

   // The count needs one extra bit beyond the pointer so full and empty differ.
   function automatic int unsigned tx_occ_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : cci_mpf_shim_pkg

// File: rtl/cci_mpf_prim_tx_fifo.sv
// One TX channel FIFO.
// Holds the storage, the wrapping read/write pointers, the entry count, the
// registered almost-full toward the AFU and the sticky overflow flag.
// The head entry is exposed combinationally. The pop strobe tells the parent
// to capture the head into its output register.
module cci_mpf_prim_tx_fifo
   import cci_mpf_shim_pkg::*;
#(
   parameter int unsigned DEPTH = TX_DEFAULT_DEPTH,
   parameter int unsigned SLACK = TX_DEFAULT_SLACK,
   parameter int unsigned WIDTH = 600
)
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enq_en_i,
   input  logic [WIDTH-1:0]        enq_data_i,
   input  logic                    deq_block_i,
   output logic                    deq_fire_o,
   output logic [WIDTH-1:0]        deq_data_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    alm_full_o,
   output logic                    overflow_o
);

   localparam int unsigned          PTR_W     = $clog2(DEPTH);
   localparam int unsigned          CNT_W     = tx_occ_width(DEPTH);
   localparam logic [CNT_W-1:0]     FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]     AF_THRESH = CNT_W'(DEPTH - SLACK);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             alm_full_q, alm_full_d;
   logic             overflow_q, overflow_d;
   logic             pop, push, drop;

   // Pop/push decision and next-state. At full, a write is accepted only
   // when a pop frees a slot in the same cycle.
   // NOTE: combinational blocks use blocking '=' and give every output a value
   //       on every path, so that no latch is inferred.
   always_comb begin
      pop        = (count_q != '0) && !deq_block_i;
      push       = enq_en_i && ((count_q != FULL_CNT) || pop);
      drop       = enq_en_i && !push;
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      alm_full_d = (count_d >= AF_THRESH);
      overflow_d = overflow_q | drop;
   end

   // Control state. Reset discards every queued entry and holds almFull high.
   // NOTE: clocked blocks use non-blocking '<=' so that every register samples
   //       the pre-edge values of the other registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         alm_full_q <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         alm_full_q <= alm_full_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage.
   // NOTE: the storage array is not reset. Reset only clears the pointers and
   //       the count, so no stale entry can be read back.
   always_ff @(posedge clk) begin
      if (reset_n && push) begin
         mem_q[wr_ptr_q] <= enq_data_i;
      end
   end

   assign deq_fire_o = pop;
   assign deq_data_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign alm_full_o = alm_full_q;
   assign overflow_o = overflow_q;

endmodule : cci_mpf_prim_tx_fifo

// File: rtl/cci_mpf_shim_tx_buffer.sv
// N-channel TX request buffer between the AFU and FIU request ports.
// Each channel is independent: a FIFO that absorbs up to SLACK requests after
// almFull is raised, drained toward the FIU when the FIU is not almost-full.
// There is no cross-channel ordering and no arbitration.
module cci_mpf_shim_tx_buffer
   import cci_mpf_shim_pkg::*;
#(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned REQ_WIDTH = 600,
   parameter int unsigned DEPTH     = TX_DEFAULT_DEPTH,
   parameter int unsigned SLACK     = TX_DEFAULT_SLACK
)
(
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [NUM_CH-1:0]                    afu_valid,
   input  logic [NUM_CH*REQ_WIDTH-1:0]          afu_req,
   output logic [NUM_CH-1:0]                    afu_almFull,
   output logic [NUM_CH-1:0]                    fiu_valid,
   output logic [NUM_CH*REQ_WIDTH-1:0]          fiu_req,
   input  logic [NUM_CH-1:0]                    fiu_almFull,
   output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]  occupancy,
   output logic [NUM_CH-1:0]                    overflow_err
);

   localparam int unsigned OCC_W = tx_occ_width(DEPTH);

   // Reject configurations the FIFO cannot implement.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("cci_mpf_shim_tx_buffer: DEPTH must be a power of 2 and at least 2");
   end
   if (DEPTH < 2 * SLACK) begin : g_bad_slack
      $error("cci_mpf_shim_tx_buffer: DEPTH must be at least 2*SLACK");
   end
   if (NUM_CH < 1 || NUM_CH > TX_MAX_CH) begin : g_bad_num_ch
      $error("cci_mpf_shim_tx_buffer: NUM_CH must be in 1..4");
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic                  deq_fire;
      logic [REQ_WIDTH-1:0]  deq_data;
      logic                  fiu_valid_q;
      logic [REQ_WIDTH-1:0]  fiu_req_q;

      cci_mpf_prim_tx_fifo #(
         .DEPTH (DEPTH),
         .SLACK (SLACK),
         .WIDTH (REQ_WIDTH)
      ) u_fifo (
         .clk         (clk),
         .reset_n     (reset_n),
         .enq_en_i    (afu_valid[ch]),
         .enq_data_i  (afu_req[ch*REQ_WIDTH +: REQ_WIDTH]),
         .deq_block_i (fiu_almFull[ch]),
         .deq_fire_o  (deq_fire),
         .deq_data_o  (deq_data),
         .count_o     (occupancy[ch*OCC_W +: OCC_W]),
         .alm_full_o  (afu_almFull[ch]),
         .overflow_o  (overflow_err[ch])
      );

      // Output register: presents the popped head for exactly one cycle.
      // The payload only loads on a pop, so it holds between pops.
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            fiu_valid_q <= 1'b0;
            fiu_req_q   <= '0;
         end else begin
            fiu_valid_q <= deq_fire;
            if (deq_fire) begin
               fiu_req_q <= deq_data;
            end
         end
      end

      assign fiu_valid[ch]                       = fiu_valid_q;
      assign fiu_req[ch*REQ_WIDTH +: REQ_WIDTH]  = fiu_req_q;
   end

endmodule : cci_mpf_shim_tx_buffer

// File: tb/tb_cci_mpf_shim_tx_buffer.sv
// Bench for cci_mpf_shim_tx_buffer.
// The reference model tracks, per channel, an entry count, the sticky overflow
// flag and a queue of accepted payloads in acceptance order. A separate monitor
// compares every FIU-side request against the head of that queue.
module tb_cci_mpf_shim_tx_buffer;

   localparam int NCH   = 2;
   localparam int W     = 600;
   localparam int DEPTH = 64;
   localparam int SLACK = 8;
   localparam int OW    = $clog2(DEPTH) + 1;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [NCH-1:0]      afu_valid;
   logic [NCH*W-1:0]    afu_req;
   logic [NCH-1:0]      afu_almFull;
   logic [NCH-1:0]      fiu_valid;
   logic [NCH*W-1:0]    fiu_req;
   logic [NCH-1:0]      fiu_almFull;
   logic [NCH*OW-1:0]   occupancy;
   logic [NCH-1:0]      overflow_err;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   int              mcnt [NCH];
   bit              movf [NCH];
   bit              mafull [NCH];
   bit              mval [NCH];
   logic [W-1:0]    exp_q [NCH][$];

   cci_mpf_shim_tx_buffer #(
      .NUM_CH    (NCH),
      .REQ_WIDTH (W),
      .DEPTH     (DEPTH),
      .SLACK     (SLACK)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .afu_valid    (afu_valid),
      .afu_req      (afu_req),
      .afu_almFull  (afu_almFull),
      .fiu_valid    (fiu_valid),
      .fiu_req      (fiu_req),
      .fiu_almFull  (fiu_almFull),
      .occupancy    (occupancy),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_req();
      logic [W-1:0] r = '0;
      for (int k = 0; k < (W + 31) / 32; k++) r = {r[W-33:0], 32'($urandom)};
      return r;
   endfunction

   // One clock edge: apply the rules to the inputs held across the edge,
   // then compare the per-channel status outputs.
   task automatic tick();
      bit pop, push;
      @(posedge clk);
      for (int ch = 0; ch < NCH; ch++) begin
         if (!reset_n) begin
            mcnt[ch]   = 0;
            movf[ch]   = 1'b0;
            mafull[ch] = 1'b1;
            mval[ch]   = 1'b0;
            exp_q[ch].delete();
         end else begin
            pop  = (mcnt[ch] > 0) && !fiu_almFull[ch];
            push = afu_valid[ch] && ((mcnt[ch] < DEPTH) || pop);
            if (push) exp_q[ch].push_back(afu_req[ch*W +: W]);
            if (afu_valid[ch] && !push) movf[ch] = 1'b1;
            mcnt[ch]   = mcnt[ch] + int'(push) - int'(pop);
            mafull[ch] = (mcnt[ch] >= DEPTH - SLACK);
            mval[ch]   = pop;
         end
      end
      #1;
      for (int ch = 0; ch < NCH; ch++) begin
         check($sformatf("occupancy[%0d]", ch), W'(occupancy[ch*OW +: OW]), W'(mcnt[ch]));
         check($sformatf("afu_almFull[%0d]", ch), W'(afu_almFull[ch]), W'(mafull[ch]));
         check($sformatf("overflow_err[%0d]", ch), W'(overflow_err[ch]), W'(movf[ch]));
         check($sformatf("fiu_valid[%0d]", ch), W'(fiu_valid[ch]), W'(mval[ch]));
      end
   endtask

   task automatic set_req(input int ch, input bit v, input logic [W-1:0] d);
      afu_valid[ch]         = v;
      afu_req[ch*W +: W]    = d;
   endtask

   task automatic push_n(input int ch, input int n);
      for (int i = 0; i < n; i++) begin
         set_req(ch, 1'b1, rand_req());
         tick();
      end
      set_req(ch, 1'b0, '0);
   endtask

   task automatic idle(input int n);
      afu_valid = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      for (int i = 0; i < n; i++) tick();
      reset_n = 1'b1;
   endtask

   // Monitor: every request toward the FIU must be the oldest accepted payload.
   always @(negedge clk) begin
      for (int ch = 0; ch < NCH; ch++) begin
         if (fiu_valid[ch] === 1'b1) begin
            check($sformatf("exp_pending[%0d]", ch), W'(exp_q[ch].size() > 0), W'(1));
            if (exp_q[ch].size() > 0)
               check($sformatf("fiu_req[%0d]", ch), fiu_req[ch*W +: W], exp_q[ch].pop_front());
         end
      end
   end

   initial begin
      reset_n     = 1'b0;
      afu_valid   = '0;
      afu_req     = '0;
      fiu_almFull = '0;

      // Reset held 3 cycles, then release: almFull drops after the first edge.
      do_reset(3);
      tick();

      // Single request latency on ch0.
      set_req(0, 1'b1, W'('hA5));
      tick();
      set_req(0, 1'b0, '0);
      idle(3);

      // Backpressure on ch1: almFull after the 56th, full at 64, then drain in order.
      fiu_almFull[1] = 1'b1;
      push_n(1, DEPTH - SLACK);
      push_n(1, SLACK);
      idle(2);
      fiu_almFull[1] = 1'b0;
      idle(DEPTH + 4);

      // Overflow on ch0: one push beyond full is dropped and flagged.
      fiu_almFull[0] = 1'b1;
      push_n(0, DEPTH);
      push_n(0, 1);
      idle(2);
      fiu_almFull[0] = 1'b0;
      idle(DEPTH + 4);

      // Full with concurrent push and pop for 200 cycles.
      do_reset(2);
      fiu_almFull[0] = 1'b1;
      push_n(0, DEPTH);
      fiu_almFull[0] = 1'b0;
      push_n(0, 200);
      idle(DEPTH + 4);

      // Reset in the middle of a drain on ch1, with ch0 also busy.
      fiu_almFull = '1;
      push_n(1, 20);
      push_n(0, 10);
      fiu_almFull = '0;
      idle(5);
      do_reset(1);
      idle(30);

      // Randomized traffic on both channels, then a full drain.
      for (int i = 0; i < 400; i++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            set_req(ch, 1'($urandom_range(0, 1)), rand_req());
            fiu_almFull[ch] = ($urandom_range(0, 3) == 0);
         end
         tick();
      end
      fiu_almFull = '0;
      idle(DEPTH + 4);
      for (int ch = 0; ch < NCH; ch++)
         check($sformatf("drain_left[%0d]", ch), W'(exp_q[ch].size()), W'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_cci_mpf_shim_tx_buffer
